// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pkg
//   Definitions shared by the fetch unit and its BTB:
//   - RESET_PC_DEF   default first fetch address
//   - btb_entry_t    one BTB line {valid, tag, target}
//   - fetch_state_e  fetch FSM encoding (FETCH / HOLD / DROP)
//   - btb_tag_of()   tag extraction for a given index width
// ----------------------------------------------------------------------------
package if_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  // Wide enough for the smallest legal BTB (2 entries -> 1 index bit).
  localparam int BTB_TAG_W = 29;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  typedef logic [1:0] fetch_state_e;
  localparam fetch_state_e FETCH = 2'd0;
  localparam fetch_state_e HOLD  = 2'd1;
  localparam fetch_state_e DROP  = 2'd2;

  // Tag is pc[31:idx_w+2], zero-extended into the fixed tag field.
  function automatic logic [BTB_TAG_W-1:0] btb_tag_of(input logic [31:0] pc,
                                                      input int          idx_w);
    return BTB_TAG_W'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/pipe_regs_pkg.sv
// ----------------------------------------------------------------------------
// pipe_regs_pkg
//   Pipeline-register word layouts shared between adjacent stages.
//   if_id_reg_t : the IF/ID word (pc, inst, valid, predicted_pc,
//                 prediction_valid) produced by fetch and consumed by decode.
// ----------------------------------------------------------------------------
package pipe_regs_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] predicted_pc;
    logic        prediction_valid;
  } if_id_reg_t;

endpackage

// File: rtl/if_fetch_unit_btb.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_btb
//   Direct-mapped branch target buffer.
//   Ports:
//     clk, rst            clock, synchronous active-high reset (clears valids)
//     lookup_pc_i         pc to predict (combinational read)
//     hit_o, target_o     lookup result
//     upd_valid_i         write enable for a resolved branch
//     upd_pc_i            pc of the resolved branch
//     upd_target_i        resolved target
//     upd_taken_i         resolved direction
//   A lookup in the same cycle as an update sees the old contents.
// ----------------------------------------------------------------------------
module if_fetch_unit_btb
  import if_fetch_unit_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc_i,
  output logic        hit_o,
  output logic [31:0] target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_taken_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t           mem_q [ENTRIES];
  logic [IDX_W-1:0]     lk_idx_s;
  logic [IDX_W-1:0]     up_idx_s;
  logic [BTB_TAG_W-1:0] up_tag_s;
  logic                 up_hit_s;
  btb_entry_t           lk_entry_s;

  assign lk_idx_s = IDX_W'(lookup_pc_i >> 2);
  assign up_idx_s = IDX_W'(upd_pc_i >> 2);
  assign up_tag_s = btb_tag_of(upd_pc_i, IDX_W);

  // Lookup: read the indexed line and qualify it with the tag.
  always_comb begin
    lk_entry_s = mem_q[lk_idx_s];
    hit_o      = lk_entry_s.valid && (lk_entry_s.tag == btb_tag_of(lookup_pc_i, IDX_W));
    target_o   = lk_entry_s.target;
    up_hit_s   = mem_q[up_idx_s].valid && (mem_q[up_idx_s].tag == up_tag_s);
  end

  // Update: taken installs the line; not-taken only evicts its own tag,
  // so an aliasing branch cannot knock out an unrelated entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else if (upd_valid_i) begin
      if (upd_taken_i) begin
        mem_q[up_idx_s] <= '{valid: 1'b1, tag: up_tag_s, target: upd_target_i};
      end else if (up_hit_s) begin
        mem_q[up_idx_s].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage: PC generation, imem request handshake, BTB
//   prediction and the IF/ID word for decode.
//   Ports:
//     clk, rst                           clock, synchronous active-high reset
//     stall                              hold the IF/ID word, accept no fetch
//     flush                              force if_id_next to zero this cycle
//     branch_redirect_id/target_id       redirect from decode
//     ex_redirect/ex_target              redirect from execute (wins over ID)
//     btb_upd_valid/pc/target/taken      BTB training from execute
//     imem_req/addr/ack/rdata            instruction memory handshake
//     if_id_next                         next IF/ID contents
// ----------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
  import pipe_regs_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_redirect_id,
  input  logic [31:0] branch_target_id,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        btb_upd_valid,
  input  logic [31:0] btb_upd_pc,
  input  logic [31:0] btb_upd_target,
  input  logic        btb_upd_taken,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output if_id_reg_t  if_id_next
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;      // address of the current/next request
  logic [31:0]  tgt_q, tgt_d;    // redirect target parked while in DROP
  if_id_reg_t   hold_q, hold_d;  // word parked while decode stalls
  logic         req_q, req_d;

  logic         hit_s;
  logic [31:0]  btb_tgt_s;
  logic [31:0]  pred_pc_s;
  logic         ack_s;
  logic         redir_s;
  logic [31:0]  redir_tgt_s;
  if_id_reg_t   fetch_word_s;
  if_id_reg_t   out_s;

  if_fetch_unit_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc_i (pc_q),
    .hit_o       (hit_s),
    .target_o    (btb_tgt_s),
    .upd_valid_i (btb_upd_valid),
    .upd_pc_i    (btb_upd_pc),
    .upd_target_i(btb_upd_target),
    .upd_taken_i (btb_upd_taken)
  );

  // An ack only counts against a request we actually issued; this also
  // drops a stale ack from a request that rst cut short.
  assign ack_s       = imem_ack && req_q;
  assign redir_s     = ex_redirect || branch_redirect_id;
  assign redir_tgt_s = ex_redirect ? ex_target : branch_target_id;
  assign pred_pc_s   = hit_s ? btb_tgt_s : (pc_q + 32'd4);

  assign fetch_word_s = '{pc: pc_q, inst: imem_rdata, valid: 1'b1,
                          predicted_pc: pred_pc_s, prediction_valid: hit_s};

  // FSM next state, pc mux and output word selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    out_s   = '0;
    case (state_q)
      FETCH: begin
        if (redir_s) begin
          if (ack_s || !req_q) begin
            pc_d    = redir_tgt_s;
            state_d = FETCH;
          end else begin
            // Request in flight cannot be cancelled at the memory.
            tgt_d   = redir_tgt_s;
            state_d = DROP;
          end
        end else if (ack_s) begin
          out_s = fetch_word_s;
          pc_d  = pred_pc_s;
          if (stall) begin
            hold_d  = fetch_word_s;
            state_d = HOLD;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redir_s) begin
          pc_d    = redir_tgt_s;
          state_d = FETCH;
        end else begin
          out_s = hold_q;
          // pc already points past the held word.
          if (stall) begin
            state_d = HOLD;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DROP: begin
        if (ack_s) begin
          pc_d    = redir_s ? redir_tgt_s : tgt_q;
          state_d = FETCH;
        end else if (redir_s) begin
          tgt_d   = redir_tgt_s;
          state_d = DROP;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = FETCH;
        pc_d    = RESET_PC;
      end
    endcase
    req_d = (state_d != HOLD);
  end

  assign if_id_next = flush ? '0 : out_s;
  assign imem_req   = req_q;
  assign imem_addr  = pc_q;

  // State, pc and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      hold_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
    end
  end

endmodule
